// File: rtl/fdiv_seq.sv
// fdiv_seq: sequential IEEE-754 single-precision divider.
// Uses restoring division that produces one quotient bit per cycle.
// Latency is fixed: the accept edge is edge 0, and s/done update at edge 27.
// This holds for special-case operands too.
//
// Ports:
//   clk    in   rising-edge clock
//   clrn   in   asynchronous active-low reset
//   a, b   in   dividend / divisor (binary32)
//   rm     in   rounding mode, 2'b00 = RNE, otherwise RZ
//   start  in   divide request (only honoured in IDLE with ein=1)
//   ein    in   pipeline enable
//   s      out  quotient, held until the next NORM edge
//   done   out  one-cycle pulse, s valid
//   busy   out  division in progress
//   stall  out  start & busy (combinational)
//   count  out  iteration counter, 0 outside DIV
`timescale 1ns / 1ps

module fdiv_seq (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  rm,
  input  logic        start,
  input  logic        ein,
  output logic [31:0] s,
  output logic        done,
  output logic        busy,
  output logic        stall,
  output logic [4:0]  count
);

  typedef enum logic [1:0] {StIdle, StDiv, StNorm} state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [1:0]  rm_q, rm_d;
  logic [24:0] rem_q, rem_d;
  logic [25:0] quo_q, quo_d;
  logic [4:0]  count_q, count_d;
  logic        done_q, done_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      rm_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      count_q <= '0;
      s_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rm_q    <= rm_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      count_q <= count_d;
      s_q     <= s_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start && ein) state_d = StDiv;
      StDiv:   if (count_q == 5'd0) state_d = StNorm;
      StNorm:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Divider step: remainder is always < 2*divisor, so 25 bits suffice.
  logic [24:0] dvs;
  logic [24:0] diff;
  logic        ge;
  logic [24:0] rem_sel;

  always_comb begin
    dvs     = {2'b01, b_q[22:0]};
    diff    = rem_q - dvs;
    ge      = (rem_q >= dvs);
    rem_sel = ge ? diff : rem_q;
  end

  // Normalise, round and resolve special cases from the finished quotient
  logic [7:0]        ea, eb;
  logic              sign;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic signed [9:0] exp_raw, exp_n, exp_f;
  logic [23:0]       mant;
  logic              guard, sticky, round_up;
  logic [24:0]       mant_r;
  logic [22:0]       frac;
  logic [31:0]       result;

  always_comb begin
    ea      = a_q[30:23];
    eb      = b_q[30:23];
    sign    = a_q[31] ^ b_q[31];
    // Denormals are treated as zero.
    a_zero  = (ea == 8'd0);
    b_zero  = (eb == 8'd0);
    a_inf   = (ea == 8'hff) && (a_q[22:0] == 23'd0);
    b_inf   = (eb == 8'hff) && (b_q[22:0] == 23'd0);
    a_nan   = (ea == 8'hff) && (a_q[22:0] != 23'd0);
    b_nan   = (eb == 8'hff) && (b_q[22:0] != 23'd0);
    exp_raw = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;

    if (quo_q[25]) begin
      mant   = quo_q[25:2];
      guard  = quo_q[1];
      sticky = quo_q[0] | (|rem_q);
      exp_n  = exp_raw;
    end else begin
      mant   = quo_q[24:1];
      guard  = quo_q[0];
      sticky = |rem_q;
      exp_n  = exp_raw - 10'sd1;
    end

    round_up = (rm_q == 2'b00) && guard && (sticky || mant[0]);
    mant_r   = {1'b0, mant} + {24'd0, round_up};
    // Carry-out leaves 1.000...; shift right and bump the exponent.
    if (mant_r[24]) begin
      frac  = mant_r[23:1];
      exp_f = exp_n + 10'sd1;
    end else begin
      frac  = mant_r[22:0];
      exp_f = exp_n;
    end

    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      result = 32'h7fc0_0000;
    end else if (a_inf || b_zero) begin
      result = {sign, 8'hff, 23'd0};
    end else if (a_zero || b_inf) begin
      result = {sign, 31'd0};
    end else if (exp_f >= 10'sd255) begin
      result = {sign, 8'hff, 23'd0};
    end else if (exp_f <= 10'sd0) begin
      result = {sign, 31'd0};
    end else begin
      result = {sign, exp_f[7:0], frac};
    end
  end

  // Register next-values and outputs
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    rm_d    = rm_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    count_d = count_q;
    s_d     = s_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && ein) begin
          a_d     = a;
          b_d     = b;
          rm_d    = rm;
          rem_d   = {2'b01, a[22:0]};
          quo_d   = '0;
          count_d = 5'd25;
        end
      end
      StDiv: begin
        rem_d   = {rem_sel[23:0], 1'b0};
        quo_d   = {quo_q[24:0], ge};
        count_d = (count_q == 5'd0) ? 5'd0 : count_q - 5'd1;
      end
      StNorm: begin
        s_d    = result;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign s     = s_q;
  assign done  = done_q;
  assign busy  = (state_q != StIdle);
  assign stall = start & busy;
  assign count = count_q;

endmodule

// File: tb/tb_fdiv_seq.sv
`timescale 1ns / 1ps

module tb_fdiv_seq;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [1:0]  rm = '0;
  logic        start = 1'b0;
  logic        ein = 1'b1;
  logic [31:0] s;
  logic        done, busy, stall;
  logic [4:0]  count;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  fdiv_seq dut (
    .clk  (clk),
    .clrn (clrn),
    .a    (a),
    .b    (b),
    .rm   (rm),
    .start(start),
    .ein  (ein),
    .s    (s),
    .done (done),
    .busy (busy),
    .stall(stall),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) check("done_without_request", 32'(exp_q.size()), 32'd1);
      else check("s_result", s, exp_q.pop_front());
    end
  end

  // Issue one divide at the next negedge and check timing through edge 27.
  // With poke set, start is re-asserted before edge 5 to exercise stall.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] trm,
                       input logic [31:0] texp, input bit poke);
    @(negedge clk);
    a = ta; b = tb; rm = trm; start = 1'b1; ein = 1'b1;
    exp_q.push_back(texp);
    @(posedge clk);
    #1 start = 1'b0;
    check("count_after_accept", count, 32'd25);
    for (int k = 1; k <= 27; k++) begin
      if (poke && k == 5) begin
        @(negedge clk);
        a = 32'h1234_5678; start = 1'b1;
        #1 check("stall_while_busy", stall, 32'd1);
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (k < 27) check($sformatf("done_busy_edge%0d", k), {done, busy}, 32'b01);
      else check("done_busy_edge27", {done, busy}, 32'b10);
      if (k == 10) check("count_edge10", count, 32'd15);
      if (k == 26) check("count_edge26", count, 32'd0);
    end
  endtask

  initial begin
    bit saw_done;
    // Reset state
    #1;
    check("rst_s", s, 32'd0);
    check("rst_busy_done", {busy, done}, 32'd0);
    check("rst_count", count, 32'd0);
    start = 1'b1;
    #1 check("rst_stall", stall, 32'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;

    // Directed vectors, all issued back-to-back in the done cycle
    do_op(32'h40c0_0000, 32'h4000_0000, 2'b00, 32'h4040_0000, 1'b0);  // 6/2
    do_op(32'h3f80_0000, 32'h4040_0000, 2'b00, 32'h3eaa_aaab, 1'b0);  // 1/3 RNE
    do_op(32'h3f80_0000, 32'h4040_0000, 2'b01, 32'h3eaa_aaaa, 1'b0);  // 1/3 RZ
    do_op(32'h3f80_0000, 32'h0000_0000, 2'b00, 32'h7f80_0000, 1'b0);  // 1/0
    do_op(32'h0000_0000, 32'h0000_0000, 2'b00, 32'h7fc0_0000, 1'b0);  // 0/0
    do_op(32'hc000_0000, 32'h7f80_0000, 2'b00, 32'h8000_0000, 1'b0);  // -2/inf
    do_op(32'h7f00_0000, 32'h3e80_0000, 2'b00, 32'h7f80_0000, 1'b0);  // overflow
    do_op(32'h40c0_0000, 32'h4000_0000, 2'b00, 32'h4040_0000, 1'b1);  // stall poke
    do_op(32'h3f80_0000, 32'h4040_0000, 2'b00, 32'h3eaa_aaab, 1'b0);  // back-to-back

    // s holds after done
    repeat (3) @(negedge clk);
    check("s_hold", s, 32'h3eaa_aaab);

    // Reset in the middle of DIV
    @(negedge clk);
    a = 32'h40c0_0000; b = 32'h4000_0000; rm = 2'b00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 clrn = 1'b0;
    #1;
    check("abort_busy", busy, 32'd0);
    check("abort_s", s, 32'd0);
    check("abort_count", count, 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    saw_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      saw_done |= done;
    end
    check("abort_no_done", saw_done, 32'd0);
    do_op(32'h40c0_0000, 32'h4000_0000, 2'b00, 32'h4040_0000, 1'b0);

    // start with ein=0 is ignored
    @(negedge clk);
    start = 1'b1; ein = 1'b0;
    @(posedge clk);
    #1 check("ein0_busy", busy, 32'd0);
    check("ein0_count", count, 32'd0);
    @(negedge clk);
    start = 1'b0; ein = 1'b1;

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fdiv_seq.md
FDIV_SEQ -- requirements
Module: fdiv_seq

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  rising-edge clock.
- clrn  in  1  reset; asynchronous, active-low.
- a  in  32  IEEE-754 single dividend.
- b  in  32  IEEE-754 single divisor.
- rm  in  2  rounding mode; 2'b00 = round-to-nearest-even, any other value = round-toward-zero.
- start  in  1  divide request; decoded fdiv from the FP control.
- ein  in  1  pipeline enable; start is ignored when ein=0.
- s  out  32  quotient result.
- done  out  1  one-cycle pulse, s valid.
- busy  out  1  division in progress.
- stall  out  1  pipeline stall request.
- count  out  5  iteration counter, for test observation.
REQ-002 The block SHALL have no parameters: widths are fixed at single precision.

Function
REQ-003 The block SHALL implement states IDLE, DIV and NORM, with transitions IDLE->DIV->NORM->IDLE.
REQ-004 An accept edge SHALL be a rising edge in IDLE with start=1 and ein=1. At that edge the block captures a, b and rm, sets count=25 and enters DIV.
REQ-005 In DIV, each edge SHALL produce one restoring-division quotient bit, MSB first, and decrement count. The edge where count=0 produces the 26th bit and enters NORM.
REQ-006 The NORM edge SHALL write s, assert done for exactly the following cycle, and return to IDLE.
REQ-007 Fixed latency SHALL apply: with the accept edge numbered 0, s and done update at edge 27. The same latency SHALL apply to special-case operands.
REQ-008 busy SHALL be 1 from after the accept edge until after edge 27, and 0 otherwise.
REQ-009 stall SHALL equal start & busy; it is combinational.
REQ-010 A start while busy SHALL be ignored and SHALL NOT disturb the operation in flight.
REQ-011 Back-to-back operation SHALL be supported: start=1 in the done cycle is accepted at the next edge.
REQ-012 s SHALL hold its value until the next NORM edge.
REQ-013 Sign SHALL be sa^sb; exponent SHALL be ea-eb+127, computed in 10-bit signed arithmetic.
REQ-014 The division SHALL use 1.ma / 1.mb, giving a 26-bit quotient Q[25:0] in which Q[25] weighs 2^0.
REQ-015 If Q[25]=1: mantissa = Q[25:2], guard = Q[1], sticky = Q[0] | (remainder != 0).
REQ-016 If Q[25]=0: mantissa = Q[24:1], guard = Q[0], sticky = (remainder != 0), and the exponent is decremented by 1.
REQ-017 Under RNE, the block SHALL increment the mantissa when guard & (sticky | lsb). A rounding carry-out SHALL renormalise and increment the exponent. RZ SHALL truncate.
REQ-018 If the final exponent >= 255, s SHALL be signed infinity. If the final exponent <= 0, s SHALL be signed zero (flush, no denormals).
REQ-019 Denormal inputs SHALL be treated as signed zero.
REQ-020 Special cases SHALL produce:
- any NaN operand, 0/0 or inf/inf: 0x7FC00000.
- finite nonzero/0 or inf/finite: signed infinity.
- 0/finite nonzero or finite/inf: signed zero.
REQ-021 count SHALL hold 0 outside DIV.

Reset
REQ-022 While clrn=0: state=IDLE, s=0, done=0, busy=0, count=0, and all internal operand and remainder registers = 0. stall then equals 0 regardless of start.
REQ-023 A reset during DIV or NORM SHALL abort the operation: no done pulse and s=0. The first accept edge after clrn rises SHALL start normally.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- a=0x40C00000, b=0x40000000, rm=00, start at edge 0 -> s=0x40400000, done high only after edge 27, busy high during edges 1..27.
- a=0x3F800000, b=0x40400000 -> s=0x3EAAAAAB with rm=00; s=0x3EAAAAAA with rm=01.
- Special cases, each with latency 27: 0x3F800000/0x00000000 -> 0x7F800000; 0x00000000/0x00000000 -> 0x7FC00000; 0xC0000000/0x7F800000 -> 0x80000000; 0x7F000000/0x3E800000 -> 0x7F800000.
- start held at edge 5 of an operation -> stall=1 that cycle, first result unchanged; start again in the done cycle -> second result after a further 27 edges.
- clrn pulsed low after edge 10 -> busy=0, s=0, count=0 immediately; no done; subsequent 6.0/2.0 returns 0x40400000.
- start=1 with ein=0 -> not accepted, busy stays 0.
